// File: rtl/egress_exit_queue_pkg.sv
// Shared Ethernet bus definitions: word geometry, frame length type, tag/address
// types, plus the exit-queue FSM states and egress word record.
package egress_exit_queue_pkg;
  localparam int ETH_WORD_W          = 128;
  localparam int ETH_WORD_BYTES      = 16;
  localparam int ETH_LEN_W           = 11;
  localparam int ETH_MAX_FRAME_WORDS = 96;

  typedef logic [ETH_LEN_W-1:0] frame_len_t;
  typedef logic [47:0]          macaddr_t;
  typedef struct packed {
    logic [2:0]  pcp;
    logic        dei;
    logic [11:0] vid;
  } vlan_t;

  typedef enum logic [1:0] {EQ_IDLE, EQ_LOAD, EQ_SEND} eq_state_e;

  typedef struct packed {
    logic [ETH_WORD_W-1:0] data;
    logic [4:0]            bytes;
    logic                  last;
  } eq_word_t;

  function automatic logic [7:0] words_of(input frame_len_t len);
    logic [11:0] t;
    t = {1'b0, len} + 12'd15;
    return t[11:4];
  endfunction

  function automatic logic [4:0] last_bytes(input frame_len_t len);
    logic [3:0] m;
    m = len[3:0] - 4'd1;
    return {1'b0, m} + 5'd1;
  endfunction
endpackage

// File: rtl/egress_exit_queue_len_fifo.sv
// Committed-frame length FIFO, first-word-fall-through, extra-bit pointers.
module exit_queue_len_fifo
  import egress_exit_queue_pkg::*;
#(
  parameter int DEPTH = 64
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  frame_len_t             i_din,
  input  logic                   i_pop,
  output frame_len_t             o_dout,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_cnt
);
  localparam int AW = $clog2(DEPTH);

  frame_len_t r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic        w_full, w_push, w_pop;

  assign o_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_cnt   = r_wr - r_rd;
  assign o_dout  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/egress_exit_queue.sv
// Store-and-forward egress exit queue: frames land in a word RAM and are released
// only once complete. Statistics counters compile in with EXIT_QUEUE_STATS_EN.
module egress_exit_queue
  import egress_exit_queue_pkg::*;
#(
  parameter int DATA_DEPTH      = 1024,
  parameter int FRAME_DEPTH     = 64,
  parameter int MAX_FRAME_WORDS = ETH_MAX_FRAME_WORDS
)(
  input  logic                  clk_ram_ctl,
  input  logic                  rst,
  input  logic                  frame_wr_en,
  input  logic [ETH_LEN_W-1:0]  frame_len,
  input  logic                  frame_valid,
  input  logic                  frame_last,
  input  logic [ETH_WORD_W-1:0] frame_data,
  output logic                  space_avail,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ETH_WORD_W-1:0] tx_data,
  output logic [4:0]            tx_bytes,
  output logic                  tx_last,
  output logic [31:0]           frames_sent,
  output logic [31:0]           frames_dropped
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int FAW = $clog2(FRAME_DEPTH);
  localparam logic [DAW:0]   DEPTH_W = (DAW+1)'(DATA_DEPTH);
  localparam logic [DAW:0]   MAXW_W  = (DAW+1)'(MAX_FRAME_WORDS);
  localparam logic [FAW+1:0] FDEP_W  = (FAW+2)'(FRAME_DEPTH);

  logic [ETH_WORD_W-1:0] r_mem [DATA_DEPTH];

  logic       r_synced, r_in_frame, r_drop, r_commit, r_space;
  frame_len_t r_len;
  logic [DAW:0] r_wr_spec, r_wr_com, r_rd_ptr;
  logic       w_acc, w_start, w_drop_beat, w_write, w_end_ok, w_end_drop;
  logic       w_data_full, w_lf_full, w_lf_empty;
  logic [DAW:0]   w_used, w_free, w_com;
  logic [FAW:0]   w_lf_cnt;
  logic [FAW+1:0] w_lf_occ;
  frame_len_t w_lf_dout;

  eq_state_e r_state, w_next;
  eq_word_t  r_tx, r_sk, w_new;
  logic      r_tx_vld, r_sk_vld, w_pop, w_issue, w_hs_last;
  logic [7:0] r_rd_left;
  logic [4:0] r_last_bytes;

  assign w_acc       = frame_valid && frame_wr_en && r_synced;
  assign w_start     = w_acc && !r_in_frame;
  assign w_used      = r_wr_spec - r_rd_ptr;
  assign w_free      = DEPTH_W - w_used;
  assign w_data_full = w_used[DAW];
  // A commit still in flight already owns a FIFO slot.
  assign w_lf_occ    = {1'b0, w_lf_cnt} + {{(FAW+1){1'b0}}, r_commit};
  assign w_lf_full   = (w_lf_occ >= FDEP_W);
  assign w_drop_beat = w_start ? ((frame_len == '0) || w_lf_full || w_data_full)
                               : (r_drop || w_data_full);
  assign w_write     = w_acc && !w_drop_beat;
  assign w_end_ok    = w_write && frame_last;
  assign w_end_drop  = w_acc && frame_last && w_drop_beat;
  assign w_com       = r_commit ? r_wr_spec : r_wr_com;

  always_ff @(posedge clk_ram_ctl)
    if (w_write) r_mem[r_wr_spec[DAW-1:0]] <= frame_data;

  always_ff @(posedge clk_ram_ctl) begin
    if (rst) begin
      r_synced   <= 1'b0;
      r_in_frame <= 1'b0;
      r_drop     <= 1'b0;
      r_commit   <= 1'b0;
      r_space    <= 1'b0;
      r_len      <= '0;
      r_wr_spec  <= '0;
      r_wr_com   <= '0;
    end else begin
      if (!frame_valid || (frame_wr_en && frame_last && !r_synced)) r_synced <= 1'b1;
      r_commit <= w_end_ok;
      r_space  <= (w_free >= MAXW_W) && !w_lf_full;
      if (r_commit) r_wr_com <= r_wr_spec;
      if (w_write) r_wr_spec <= r_wr_spec + 1'b1;
      else if (w_end_drop) r_wr_spec <= w_com;
      if (w_start) r_len <= frame_len;
      if (w_acc) begin
        r_in_frame <= !frame_last;
        r_drop     <= !frame_last && w_drop_beat;
      end
    end
  end

  exit_queue_len_fifo #(.DEPTH(FRAME_DEPTH)) u_len_fifo (
    .clk(clk_ram_ctl), .rst(rst), .i_push(r_commit), .i_din(r_len),
    .i_pop(w_pop), .o_dout(w_lf_dout), .o_empty(w_lf_empty), .o_cnt(w_lf_cnt)
  );

  assign w_hs_last = r_tx_vld && tx_ready && r_tx.last;

  always_ff @(posedge clk_ram_ctl)
    if (rst) r_state <= EQ_IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      EQ_IDLE: if (!w_lf_empty) w_next = EQ_LOAD;
      EQ_LOAD: w_next = EQ_SEND;
      EQ_SEND: if (w_hs_last) w_next = w_lf_empty ? EQ_IDLE : EQ_LOAD;
      default: w_next = EQ_IDLE;
    endcase
  end

  // Reads go straight into the output register, or the skid when the output is held.
  always_comb begin
    w_pop   = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      EQ_IDLE: w_pop = !w_lf_empty;
      EQ_LOAD: w_issue = 1'b1;
      EQ_SEND: begin
        w_pop   = w_hs_last && !w_lf_empty;
        w_issue = (r_rd_left != 8'd0) && !(r_sk_vld && !tx_ready);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_new.data  = r_mem[r_rd_ptr[DAW-1:0]];
    w_new.last  = (r_rd_left == 8'd1);
    w_new.bytes = w_new.last ? r_last_bytes : 5'(ETH_WORD_BYTES);
  end

  always_ff @(posedge clk_ram_ctl) begin
    if (rst) begin
      r_tx         <= '0;
      r_sk         <= '0;
      r_tx_vld     <= 1'b0;
      r_sk_vld     <= 1'b0;
      r_rd_ptr     <= '0;
      r_rd_left    <= '0;
      r_last_bytes <= '0;
    end else begin
      if (w_pop) begin
        r_rd_left    <= words_of(w_lf_dout);
        r_last_bytes <= last_bytes(w_lf_dout);
      end else if (w_issue) begin
        r_rd_left <= r_rd_left - 8'd1;
      end
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (!r_tx_vld || tx_ready) begin
        if (r_sk_vld) begin
          r_tx     <= r_sk;
          r_tx_vld <= 1'b1;
          r_sk_vld <= w_issue;
          if (w_issue) r_sk <= w_new;
        end else if (w_issue) begin
          r_tx     <= w_new;
          r_tx_vld <= 1'b1;
        end else begin
          r_tx_vld <= 1'b0;
        end
      end else if (w_issue) begin
        r_sk     <= w_new;
        r_sk_vld <= 1'b1;
      end
    end
  end

  assign space_avail = r_space;
  assign tx_valid    = r_tx_vld;
  assign tx_data     = r_tx.data;
  assign tx_bytes    = r_tx.bytes;
  assign tx_last     = r_tx.last;

`ifdef EXIT_QUEUE_STATS_EN
  logic [31:0] r_sent, r_dropped;
  always_ff @(posedge clk_ram_ctl) begin
    if (rst) begin
      r_sent    <= '0;
      r_dropped <= '0;
    end else begin
      if (w_hs_last)  r_sent    <= r_sent + 32'd1;
      if (w_end_drop) r_dropped <= r_dropped + 32'd1;
    end
  end
  assign frames_sent    = r_sent;
  assign frames_dropped = r_dropped;
`else
  assign frames_sent    = '0;
  assign frames_dropped = '0;
`endif
endmodule
